// File: rtl/mac_rx_frame_buffer_pkg.sv
// Shared definitions for the MAC receive frame buffer.
// Supplies the interface width macros (default values unless the build
// provides its own), the write-FSM state enum and the stored beat struct.

`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_INTERFACE_BYTES
`define MAC_INTERFACE_BYTES 32
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 14
`endif

package mac_rx_frame_buffer_pkg;

  localparam int MAC_INTERFACE_W     = `MAC_INTERFACE_W;
  localparam int MAC_INTERFACE_BYTES = `MAC_INTERFACE_BYTES;
  localparam int MAC_PADBYTES_W      = `MAC_PADBYTES_W;
  localparam int MTU_SIZE_W          = `MTU_SIZE_W;

  // Write-side FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } rx_buf_state_e;

  // One data RAM entry.
  typedef struct packed {
    logic [MAC_INTERFACE_W-1:0] data;
    logic                       last;
    logic [MAC_PADBYTES_W-1:0]  padbytes;
  } mac_beat_t;

endpackage

// File: rtl/sync_fifo_1r1w.sv
// Generic synchronous FIFO, one write port and one read port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_val/wr_data  push (ignored while full)
//   full            no space left
//   rd_req          pop the head (ignored while empty)
//   rd_data         head entry, combinational read of the registered pointer
//   empty           nothing stored
// A push and a pop in the same cycle both take effect.

module sync_fifo_1r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_val,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit separates full from empty.
  assign full    = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_val && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_val && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_req && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mac_rx_frame_buffer.sv
// Store-and-forward receive buffer between the MAC RX interface and the
// frame formatter. Whole frames are absorbed (the MAC cannot be stalled),
// counted in bytes, and only replayed once complete and error-free.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mac_rx_*                 MAC beat input (val/data/last/padbytes/err)
//   buf_dst_*                replay output (val/data/frame_size/last/padbytes)
//   dst_buf_rdy              downstream ready
//   buf_drop_err             one-cycle pulse: frame dropped, MAC error
//   buf_drop_ovf             one-cycle pulse: frame dropped, overflow/oversize
//   dbg_wr_state             current write-FSM state
//
// Output handshake: a beat transfers on a cycle where buf_dst_val and
// dst_buf_rdy are both high. buf_dst_val is high whenever at least one
// committed frame is held, so it never drops inside a frame; the beat and
// frame_size stay stable until accepted.

module mac_rx_frame_buffer
  import mac_rx_frame_buffer_pkg::*;
#(
  parameter int DATA_DEPTH      = 256,
  parameter int SIZE_DEPTH      = 16,
  parameter int MAX_FRAME_BEATS = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_rx_val,
  input  logic [MAC_INTERFACE_W-1:0] mac_rx_data,
  input  logic                       mac_rx_last,
  input  logic [MAC_PADBYTES_W-1:0]  mac_rx_padbytes,
  input  logic                       mac_rx_err,
  output logic                       buf_dst_val,
  output logic [MAC_INTERFACE_W-1:0] buf_dst_data,
  output logic [MTU_SIZE_W-1:0]      buf_dst_frame_size,
  output logic                       buf_dst_last,
  output logic [MAC_PADBYTES_W-1:0]  buf_dst_padbytes,
  input  logic                       dst_buf_rdy,
  output logic                       buf_drop_err,
  output logic                       buf_drop_ovf,
  output rx_buf_state_e              dbg_wr_state
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = $clog2(MAX_FRAME_BEATS + 1);

  if (MAX_FRAME_BEATS * MAC_INTERFACE_BYTES >= (2 ** MTU_SIZE_W)) begin : g_size_chk
    $error("MAX_FRAME_BEATS * MAC_INTERFACE_BYTES does not fit in MTU_SIZE_W");
  end
  if ((1 << AW) != DATA_DEPTH) begin : g_depth_chk
    $error("DATA_DEPTH must be a power of 2");
  end

  mac_beat_t      ram [DATA_DEPTH];
  logic [AW:0]    wr_ptr_spec;
  logic [AW:0]    wr_ptr_commit;
  logic [AW:0]    rd_ptr;
  rx_buf_state_e  state;
  logic [CW-1:0]  beat_cnt;

  logic                  ram_full;
  logic                  size_full;
  logic                  size_empty;
  logic [MTU_SIZE_W-1:0] size_head;
  logic                  do_write;
  logic                  do_commit;
  logic [CW-1:0]         cnt_incl;
  logic [MTU_SIZE_W-1:0] commit_size;
  mac_beat_t             beat_in;
  mac_beat_t             beat_out;
  logic                  rd_fire;
  logic                  rd_pop;

  assign ram_full = (wr_ptr_spec - rd_ptr) == (AW+1)'(DATA_DEPTH);

  // Write and commit decisions are combinational so the size FIFO push
  // lands on the same edge as the last data beat.
  always_comb begin
    do_write = 1'b0;
    cnt_incl = CW'(1);
    case (state)
      ST_IDLE: do_write = mac_rx_val && !ram_full && !size_full &&
                          !(mac_rx_last && mac_rx_err);
      ST_RECV: begin
        do_write = mac_rx_val && !ram_full &&
                   (beat_cnt != CW'(MAX_FRAME_BEATS)) &&
                   !(mac_rx_last && mac_rx_err);
        cnt_incl = beat_cnt + CW'(1);
      end
      default: do_write = 1'b0;
    endcase
    do_commit   = do_write && mac_rx_last;
    commit_size = MTU_SIZE_W'(cnt_incl) * MTU_SIZE_W'(MAC_INTERFACE_BYTES)
                  - MTU_SIZE_W'(mac_rx_padbytes);
  end

  // Padbytes only stored on the final beat so the replay shows zero elsewhere.
  assign beat_in = '{data:     mac_rx_data,
                     last:     mac_rx_last,
                     padbytes: mac_rx_last ? mac_rx_padbytes : '0};

  always_ff @(posedge clk) begin
    if (do_write) ram[wr_ptr_spec[AW-1:0]] <= beat_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wr_ptr_spec   <= '0;
      wr_ptr_commit <= '0;
      beat_cnt      <= '0;
      buf_drop_err  <= 1'b0;
      buf_drop_ovf  <= 1'b0;
    end else begin
      buf_drop_err <= 1'b0;
      buf_drop_ovf <= 1'b0;
      if (do_write) wr_ptr_spec <= wr_ptr_spec + 1'b1;
      if (do_commit) wr_ptr_commit <= wr_ptr_spec + 1'b1;
      case (state)
        ST_IDLE: begin
          if (mac_rx_val) begin
            if (ram_full || size_full) begin
              // A full single-beat frame ends here; otherwise skip the rest.
              if (mac_rx_last) buf_drop_ovf <= 1'b1;
              else             state        <= ST_DISCARD;
            end else if (mac_rx_last && mac_rx_err) begin
              buf_drop_err <= 1'b1;
            end else if (!mac_rx_last) begin
              beat_cnt <= CW'(1);
              state    <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (mac_rx_val) begin
            if (ram_full || beat_cnt == CW'(MAX_FRAME_BEATS)) begin
              wr_ptr_spec <= wr_ptr_commit;
              if (mac_rx_last) begin
                buf_drop_ovf <= 1'b1;
                state        <= ST_IDLE;
              end else begin
                state <= ST_DISCARD;
              end
            end else if (mac_rx_last && mac_rx_err) begin
              wr_ptr_spec  <= wr_ptr_commit;
              buf_drop_err <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              beat_cnt <= cnt_incl;
              if (mac_rx_last) state <= ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (mac_rx_val && mac_rx_last) begin
            buf_drop_ovf <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo_1r1w #(
    .WIDTH (MTU_SIZE_W),
    .DEPTH (SIZE_DEPTH)
  ) u_size_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_val  (do_commit),
    .wr_data (commit_size),
    .full    (size_full),
    .rd_req  (rd_pop),
    .rd_data (size_head),
    .empty   (size_empty)
  );

  assign beat_out = ram[rd_ptr[AW-1:0]];
  assign rd_fire  = buf_dst_val && dst_buf_rdy;
  assign rd_pop   = rd_fire && beat_out.last;

  always_ff @(posedge clk) begin
    if (rst)          rd_ptr <= '0;
    else if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
  end

  // Outputs forced to zero while idle so stale or uninitialised RAM never shows.
  assign buf_dst_val        = !size_empty;
  assign buf_dst_data       = buf_dst_val ? beat_out.data     : '0;
  assign buf_dst_last       = buf_dst_val ? beat_out.last     : 1'b0;
  assign buf_dst_padbytes   = buf_dst_val ? beat_out.padbytes : '0;
  assign buf_dst_frame_size = buf_dst_val ? size_head         : '0;
  assign dbg_wr_state       = state;

endmodule

// File: tb/tb_mac_rx_frame_buffer.sv
module tb_mac_rx_frame_buffer;
  import mac_rx_frame_buffer_pkg::*;

  localparam int W  = MAC_INTERFACE_W;
  localparam int PW = MAC_PADBYTES_W;
  localparam int SW = MTU_SIZE_W;

  logic          clk;
  logic          rst;
  logic          mac_rx_val;
  logic [W-1:0]  mac_rx_data;
  logic          mac_rx_last;
  logic [PW-1:0] mac_rx_padbytes;
  logic          mac_rx_err;
  logic          buf_dst_val;
  logic [W-1:0]  buf_dst_data;
  logic [SW-1:0] buf_dst_frame_size;
  logic          buf_dst_last;
  logic [PW-1:0] buf_dst_padbytes;
  logic          dst_buf_rdy;
  logic          buf_drop_err;
  logic          buf_drop_ovf;
  rx_buf_state_e dbg_wr_state;

  int total = 0;
  int bad   = 0;
  int n_err = 0;
  int n_ovf = 0;
  logic [W-1:0] exp_q[$];

  mac_rx_frame_buffer #(
    .DATA_DEPTH      (256),
    .SIZE_DEPTH      (16),
    .MAX_FRAME_BEATS (48)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mac_rx_val         (mac_rx_val),
    .mac_rx_data        (mac_rx_data),
    .mac_rx_last        (mac_rx_last),
    .mac_rx_padbytes    (mac_rx_padbytes),
    .mac_rx_err         (mac_rx_err),
    .buf_dst_val        (buf_dst_val),
    .buf_dst_data       (buf_dst_data),
    .buf_dst_frame_size (buf_dst_frame_size),
    .buf_dst_last       (buf_dst_last),
    .buf_dst_padbytes   (buf_dst_padbytes),
    .dst_buf_rdy        (dst_buf_rdy),
    .buf_drop_err       (buf_drop_err),
    .buf_drop_ovf       (buf_drop_ovf),
    .dbg_wr_state       (dbg_wr_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drop pulse counters (each pulse is one cycle wide).
  always @(posedge clk) begin
    if (buf_drop_err) n_err++;
    if (buf_drop_ovf) n_ovf++;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int fid, input int b);
    logic [15:0] f16;
    logic [15:0] b16;
    f16 = 16'(fid);
    b16 = 16'(b);
    return {(W/32){f16, b16}};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Driver: presents one beat at a negedge, returns at the next negedge.
  task automatic drive_beat(input logic [W-1:0] d, input logic l,
                            input logic [PW-1:0] p, input logic e);
    mac_rx_val      = 1'b1;
    mac_rx_data     = d;
    mac_rx_last     = l;
    mac_rx_padbytes = p;
    mac_rx_err      = e;
    @(posedge clk);
    @(negedge clk);
    mac_rx_val      = 1'b0;
    mac_rx_data     = '0;
    mac_rx_last     = 1'b0;
    mac_rx_padbytes = '0;
    mac_rx_err      = 1'b0;
  endtask

  task automatic send_frame(input int fid, input int nb, input logic [PW-1:0] pad,
                            input logic err, input logic keep);
    for (int b = 0; b < nb; b++) begin
      if (keep) exp_q.push_back(mk(fid, b));
      drive_beat(mk(fid, b), b == nb - 1, (b == nb - 1) ? pad : '0,
                 (b == nb - 1) ? err : 1'b0);
    end
  endtask

  // Reads one frame with rdy=1, checking every beat against the scoreboard.
  task automatic read_frame(input int nb, input logic [SW-1:0] size, input logic [PW-1:0] pad);
    logic [W-1:0] e;
    dst_buf_rdy = 1'b1;
    for (int i = 0; i < nb; i++) begin
      int t;
      t = 0;
      while (!buf_dst_val && t < 100) begin
        idle(1);
        t++;
      end
      chk("rd_val", W'(buf_dst_val), W'(1));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("rd_data", buf_dst_data, e);
      chk("rd_size", W'(buf_dst_frame_size), W'(size));
      chk("rd_last", W'(buf_dst_last), W'(i == nb - 1));
      chk("rd_pad", W'(buf_dst_padbytes), (i == nb - 1) ? W'(pad) : W'(0));
      idle(1);
    end
    dst_buf_rdy = 1'b0;
  endtask

  initial begin
    int e0;
    int o0;
    rst = 1'b1;
    mac_rx_val = 1'b0;
    mac_rx_data = '0;
    mac_rx_last = 1'b0;
    mac_rx_padbytes = '0;
    mac_rx_err = 1'b0;
    dst_buf_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_val", W'(buf_dst_val), W'(0));
    chk("rst_data", buf_dst_data, W'(0));
    chk("rst_size", W'(buf_dst_frame_size), W'(0));
    chk("rst_last", W'(buf_dst_last), W'(0));
    chk("rst_pad", W'(buf_dst_padbytes), W'(0));
    chk("rst_drop", W'({buf_drop_err, buf_drop_ovf}), W'(0));
    chk("rst_state", W'(dbg_wr_state), W'(ST_IDLE));

    // 3-beat frame, pad 10: size 3*32-10 = 86, output the cycle after last
    dst_buf_rdy = 1'b1;
    exp_q.push_back(mk(1, 0));
    drive_beat(mk(1, 0), 1'b0, '0, 1'b0);
    exp_q.push_back(mk(1, 1));
    drive_beat(mk(1, 1), 1'b0, '0, 1'b0);
    chk("t1_val_before_last", W'(buf_dst_val), W'(0));
    exp_q.push_back(mk(1, 2));
    drive_beat(mk(1, 2), 1'b1, PW'(10), 1'b0);
    chk("t1_val_latency", W'(buf_dst_val), W'(1));
    read_frame(3, SW'(86), PW'(10));
    chk("t1_empty", W'(buf_dst_val), W'(0));

    // 1-beat frame, pad 18: size 14
    send_frame(2, 1, PW'(18), 1'b0, 1'b1);
    read_frame(1, SW'(14), PW'(18));
    chk("t2_empty", W'(buf_dst_val), W'(0));

    // 4-beat frame with err, then good 2-beat frame (size 64)
    e0 = n_err;
    o0 = n_ovf;
    send_frame(3, 4, PW'(0), 1'b1, 1'b0);
    send_frame(4, 2, PW'(0), 1'b0, 1'b1);
    idle(2);
    chk("t3_err_pulses", W'(n_err - e0), W'(1));
    chk("t3_ovf_pulses", W'(n_ovf - o0), W'(0));
    read_frame(2, SW'(64), PW'(0));
    chk("t3_empty", W'(buf_dst_val), W'(0));

    // 9 back-to-back 32-beat frames with rdy=0: 8 fill the RAM, the 9th drops
    o0 = n_ovf;
    for (int f = 0; f < 9; f++) send_frame(10 + f, 32, PW'(0), 1'b0, f < 8);
    idle(2);
    chk("t4_ovf_pulses", W'(n_ovf - o0), W'(1));
    chk("t4_state", W'(dbg_wr_state), W'(ST_IDLE));
    for (int f = 0; f < 8; f++) read_frame(32, SW'(1024), PW'(0));
    chk("t4_empty", W'(buf_dst_val), W'(0));

    // 17 one-beat frames with rdy=0: size FIFO holds 16, 17th drops
    o0 = n_ovf;
    for (int f = 0; f < 17; f++) send_frame(30 + f, 1, PW'(0), 1'b0, f < 16);
    idle(2);
    chk("t5_ovf_pulses", W'(n_ovf - o0), W'(1));
    chk("t5_state", W'(dbg_wr_state), W'(ST_IDLE));
    for (int f = 0; f < 16; f++) read_frame(1, SW'(32), PW'(0));
    chk("t5_empty", W'(buf_dst_val), W'(0));

    // Reset during beat 2 of a 5-beat frame; a committed frame is flushed too
    send_frame(50, 1, PW'(0), 1'b0, 1'b0);
    chk("t6_pre_val", W'(buf_dst_val), W'(1));
    drive_beat(mk(51, 0), 1'b0, '0, 1'b0);
    rst = 1'b1;
    drive_beat(mk(51, 1), 1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("t6_val", W'(buf_dst_val), W'(0));
    chk("t6_data", buf_dst_data, W'(0));
    chk("t6_size", W'(buf_dst_frame_size), W'(0));
    chk("t6_last", W'(buf_dst_last), W'(0));
    chk("t6_state", W'(dbg_wr_state), W'(ST_IDLE));
    exp_q.delete();
    // Remaining beats 3..5 form a new 3-beat frame: 96-4 = 92
    for (int b = 2; b < 5; b++) begin
      exp_q.push_back(mk(51, b));
      drive_beat(mk(51, b), b == 4, (b == 4) ? PW'(4) : PW'(0), 1'b0);
    end
    send_frame(52, 2, PW'(1), 1'b0, 1'b1);
    read_frame(3, SW'(92), PW'(4));
    read_frame(2, SW'(63), PW'(1));
    chk("t6_empty", W'(buf_dst_val), W'(0));
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
